// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO serial transmit controller.
package piso_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned GAP_DEF   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/piso_shifter.sv
// Parallel-load, right-shift register; load wins over shift, LSB is the serial tap.
module piso_shifter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             q_lsb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= parallel_in;
        end else if (shift_en) begin
            sr <= {1'b0, sr[WIDTH-1:1]};
        end
    end

    assign q_lsb = sr[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Framed serial transmitter: accepts a word by valid/ready, shifts exactly WIDTH bits
// LSB first, then holds off for GAP idle cycles before the next word.
module piso_tx_ctrl
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned GAP   = GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nx;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nx;
    logic               load, shift_en, q_lsb;
    logic [WIDTH-1:0]   load_data;

    // Abort in IDLE refuses a coincident handshake.
    assign in_ready = (state == ST_IDLE) && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            gap_cnt <= gap_cnt_nx;
        end
    end

    // Next state, counters and shifter controls; abort clears the shifter by loading zero.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        gap_cnt_nx = gap_cnt;
        load       = 1'b0;
        shift_en   = 1'b0;
        load_data  = in_data;
        if (abort && (state != ST_IDLE)) begin
            state_nx   = ST_IDLE;
            bit_cnt_nx = '0;
            gap_cnt_nx = '0;
            load       = 1'b1;
            load_data  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        load       = 1'b1;
                        bit_cnt_nx = '0;
                        state_nx   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_en   = 1'b1;
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nx = '0;
                        gap_cnt_nx = '0;
                        state_nx   = (GAP > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    gap_cnt_nx = gap_cnt + GAP_W'(1);
                    if (gap_cnt == LAST_GAP) begin
                        gap_cnt_nx = '0;
                        state_nx   = ST_IDLE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    piso_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .shift_en   (shift_en),
        .parallel_in(load_data),
        .q_lsb      (q_lsb)
    );

    assign serial_valid = (state == ST_SHIFT);
    assign serial_out   = (state == ST_SHIFT) && q_lsb;
    assign busy         = (state != ST_IDLE);
    assign word_done    = (state == ST_SHIFT) && (bit_cnt == LAST_BIT) && !abort;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: GAP=1 and GAP=0 instances on shared stimulus, checked against
// a queue-of-frame-slots reference model, a directed vector table and corner sequences.
module tb_piso_tx_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         abort;
    logic [W-1:0] in_data;
    logic [1:0]   rdy, so, sv, bz, wd;

    always #5 clk = ~clk;

    piso_tx_ctrl #(.WIDTH(W), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
        .abort(abort), .serial_out(so[1]), .serial_valid(sv[1]), .busy(bz[1]), .word_done(wd[1])
    );

    piso_tx_ctrl #(.WIDTH(W), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
        .abort(abort), .serial_out(so[0]), .serial_valid(sv[0]), .busy(bz[0]), .word_done(wd[0])
    );

    // One slot per upcoming output cycle of an accepted word: data bits then gap cycles.
    typedef struct packed {
        logic v;
        logic b;
        logic d;
    } slot_t;

    // Directed vector: inputs, then expected {serial_out, serial_valid, word_done, in_ready, busy}.
    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
        logic         a;
        logic [4:0]   e;
    } vec_t;

    slot_t mq [2][$];
    int    wd_t [2][$];
    vec_t  tbl [18];
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s gap=%0d t=%0t got=%0h want=%0h", name, g, $time, act, exp);
        end
    endtask

    task automatic check_model();
        for (int g = 0; g < 2; g++) begin
            logic e_so, e_sv, e_wd, e_rdy, e_bz;
            if (mq[g].size() > 0) begin
                e_so  = mq[g][0].b;
                e_sv  = mq[g][0].v;
                e_wd  = mq[g][0].d & ~abort;
                e_rdy = 1'b0;
                e_bz  = 1'b1;
            end else begin
                e_so  = 1'b0;
                e_sv  = 1'b0;
                e_wd  = 1'b0;
                e_rdy = ~abort;
                e_bz  = 1'b0;
            end
            chk("mdl_serial_out", g, 32'(so[g]), 32'(e_so));
            chk("mdl_serial_valid", g, 32'(sv[g]), 32'(e_sv));
            chk("mdl_word_done", g, 32'(wd[g]), 32'(e_wd));
            chk("mdl_in_ready", g, 32'(rdy[g]), 32'(e_rdy));
            chk("mdl_busy", g, 32'(bz[g]), 32'(e_bz));
        end
    endtask

    task automatic model_edge();
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                mq[g].delete();
            end else if (mq[g].size() > 0) begin
                if (abort) mq[g].delete();
                else void'(mq[g].pop_front());
            end else if (in_valid && !abort) begin
                for (int k = 0; k < W; k++) mq[g].push_back('{1'b1, in_data[k], (k == W - 1)});
                for (int k = 0; k < g; k++) mq[g].push_back('{1'b0, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic a);
        in_valid = v;
        in_data  = d;
        abort    = a;
        #1;
        check_model();
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0;

        tbl[0]  = {1'b1, 4'hB, 1'b0, 5'b00010};
        tbl[1]  = {1'b0, 4'h0, 1'b0, 5'b11001};
        tbl[2]  = {1'b0, 4'h0, 1'b0, 5'b11001};
        tbl[3]  = {1'b0, 4'h0, 1'b0, 5'b01001};
        tbl[4]  = {1'b0, 4'h0, 1'b0, 5'b11101};
        tbl[5]  = {1'b0, 4'h0, 1'b0, 5'b00001};
        tbl[6]  = {1'b1, 4'h6, 1'b0, 5'b00010};
        tbl[7]  = {1'b0, 4'h0, 1'b0, 5'b01001};
        tbl[8]  = {1'b0, 4'h0, 1'b0, 5'b11001};
        tbl[9]  = {1'b0, 4'h0, 1'b1, 5'b11001};
        tbl[10] = {1'b1, 4'h9, 1'b0, 5'b00010};
        tbl[11] = {1'b0, 4'h0, 1'b0, 5'b11001};
        tbl[12] = {1'b0, 4'h0, 1'b0, 5'b01001};
        tbl[13] = {1'b0, 4'h0, 1'b0, 5'b01001};
        tbl[14] = {1'b0, 4'h0, 1'b0, 5'b11101};
        tbl[15] = {1'b0, 4'h0, 1'b0, 5'b00001};
        tbl[16] = {1'b1, 4'h5, 1'b1, 5'b00000};
        tbl[17] = {1'b0, 4'h0, 1'b0, 5'b00010};

        // Reset values.
        @(negedge clk);
        step(1'b0, '0, 1'b0);
        chk("rst_in_ready", 1, 32'(rdy[1]), 32'd1);
        chk("rst_serial_out", 1, 32'(so[1]), 32'd0);
        chk("rst_serial_valid", 1, 32'(sv[1]), 32'd0);
        chk("rst_busy", 1, 32'(bz[1]), 32'd0);
        chk("rst_word_done", 1, 32'(wd[1]), 32'd0);
        tick();
        rst = 1'b0;

        // Basic word, abort mid-word, recovery word, abort refusing a handshake in IDLE.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].a);
            chk($sformatf("tbl%0d_serial_out", i), 1, 32'(so[1]), 32'(tbl[i].e[4]));
            chk($sformatf("tbl%0d_serial_valid", i), 1, 32'(sv[1]), 32'(tbl[i].e[3]));
            chk($sformatf("tbl%0d_word_done", i), 1, 32'(wd[1]), 32'(tbl[i].e[2]));
            chk($sformatf("tbl%0d_in_ready", i), 1, 32'(rdy[1]), 32'(tbl[i].e[1]));
            chk($sformatf("tbl%0d_busy", i), 1, 32'(bz[1]), 32'(tbl[i].e[0]));
            tick();
        end

        // Back-to-back with in_valid held (also stalls while busy): word period per GAP.
        for (int c = 0; c < 14; c++) begin
            step(1'b1, (c < 6) ? 4'hA : 4'h5, 1'b0);
            for (int g = 0; g < 2; g++) if (wd[g]) wd_t[g].push_back(c);
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, '0, 1'b0);
            tick();
        end
        for (int g = 0; g < 2; g++)
            chk("b2b_period", g, (wd_t[g].size() >= 2) ? 32'(wd_t[g][1] - wd_t[g][0]) : 32'd0,
                (g == 1) ? 32'd6 : 32'd5);

        // Asynchronous reset during bit 1, then a clean word.
        step(1'b1, 4'hC, 1'b0);
        tick();
        step(1'b0, '0, 1'b0);
        tick();
        step(1'b0, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        mq[0].delete();
        mq[1].delete();
        chk("arst_serial_valid", 1, 32'(sv[1]), 32'd0);
        chk("arst_serial_out", 1, 32'(so[1]), 32'd0);
        chk("arst_busy", 1, 32'(bz[1]), 32'd0);
        chk("arst_in_ready", 1, 32'(rdy[1]), 32'd1);
        check_model();
        tick();
        rst = 1'b0;
        step(1'b1, 4'h3, 1'b0);
        tick();
        for (int k = 0; k < W; k++) begin
            logic [W-1:0] w3;
            w3 = 4'h3;
            step(1'b0, '0, 1'b0);
            chk($sformatf("arst_word_bit%0d", k), 1, 32'(so[1]), 32'(w3[k]));
            tick();
        end

        // Randomized traffic with occasional aborts.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 15) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
